// File: rtl/triangle_raster.sv
// Rasterization sequencer: latches one triangle, clips its bounding box to VRAM,
// and walks the box in raster order, forwarding inside pixels to the framebuffer writer.
module triangle_raster #(
  parameter int XMAX = 1023,
  parameter int YMAX = 511
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [15:0] tri_x0,
  input  logic [15:0] tri_y0,
  input  logic [15:0] tri_x1,
  input  logic [15:0] tri_y1,
  input  logic [15:0] tri_x2,
  input  logic [15:0] tri_y2,
  input  logic [1:0]  tri_side0,
  input  logic [1:0]  tri_side1,
  input  logic [1:0]  tri_side2,
  output logic [15:0] fill_x0,
  output logic [15:0] fill_y0,
  output logic [15:0] fill_x1,
  output logic [15:0] fill_y1,
  output logic [15:0] fill_x2,
  output logic [15:0] fill_y2,
  output logic [1:0]  fill_side0,
  output logic [1:0]  fill_side1,
  output logic [1:0]  fill_side2,
  output logic [15:0] fill_x,
  output logic [15:0] fill_y,
  input  logic        fill_in,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic [15:0] pix_x,
  output logic [15:0] pix_y,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, SETUP, SCAN, DONE} state_t;

  localparam logic [15:0] XLIM = 16'(XMAX);
  localparam logic [15:0] YLIM = 16'(YMAX);

  state_t      state_q;
  logic [15:0] x0_q, y0_q, x1_q, y1_q, x2_q, y2_q;
  logic [1:0]  side0_q, side1_q, side2_q;
  logic [15:0] cur_x_q, cur_y_q;
  logic [15:0] min_x_q, max_x_q, min_y_q, max_y_q;

  logic [15:0] min_x_d, max_x_d, min_y_d, max_y_d;
  logic        empty_d;
  logic        last_x, last_y, advance;

  function automatic logic [15:0] min3(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
    logic [15:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [15:0] max3(input logic [15:0] a, input logic [15:0] b,
                                       input logic [15:0] c);
    logic [15:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  function automatic logic [15:0] clip(input logic [15:0] v, input logic [15:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  always_comb begin
    min_x_d = min3(x0_q, x1_q, x2_q);
    min_y_d = min3(y0_q, y1_q, y2_q);
    max_x_d = clip(max3(x0_q, x1_q, x2_q), XLIM);
    max_y_d = clip(max3(y0_q, y1_q, y2_q), YLIM);
    // A box lying wholly beyond the clip edge ends up with min > max.
    empty_d = (min_x_d > max_x_d) || (min_y_d > max_y_d);
  end

  assign last_x  = (cur_x_q == max_x_q);
  assign last_y  = (cur_y_q == max_y_q);
  assign advance = !fill_in || pix_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      x1_q    <= '0;
      y1_q    <= '0;
      x2_q    <= '0;
      y2_q    <= '0;
      side0_q <= '0;
      side1_q <= '0;
      side2_q <= '0;
      cur_x_q <= '0;
      cur_y_q <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      min_y_q <= '0;
      max_y_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (tri_valid) begin
            x0_q    <= tri_x0;
            y0_q    <= tri_y0;
            x1_q    <= tri_x1;
            y1_q    <= tri_y1;
            x2_q    <= tri_x2;
            y2_q    <= tri_y2;
            side0_q <= tri_side0;
            side1_q <= tri_side1;
            side2_q <= tri_side2;
            state_q <= SETUP;
          end
        end
        SETUP: begin
          min_x_q <= min_x_d;
          max_x_q <= max_x_d;
          min_y_q <= min_y_d;
          max_y_q <= max_y_d;
          cur_x_q <= min_x_d;
          cur_y_q <= min_y_d;
          state_q <= empty_d ? DONE : SCAN;
        end
        SCAN: begin
          // An inside pixel refused by the writer freezes the walk.
          if (advance) begin
            if (!last_x) begin
              cur_x_q <= cur_x_q + 16'd1;
            end else if (!last_y) begin
              cur_x_q <= min_x_q;
              cur_y_q <= cur_y_q + 16'd1;
            end else begin
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Handshake outputs are forced low for as long as reset is held.
  assign tri_ready = !rst && (state_q == IDLE);
  assign busy      = !rst && (state_q != IDLE);
  assign done      = !rst && (state_q == DONE);
  assign pix_valid = !rst && (state_q == SCAN) && fill_in;

  assign fill_x0    = x0_q;
  assign fill_y0    = y0_q;
  assign fill_x1    = x1_q;
  assign fill_y1    = y1_q;
  assign fill_x2    = x2_q;
  assign fill_y2    = y2_q;
  assign fill_side0 = side0_q;
  assign fill_side1 = side1_q;
  assign fill_side2 = side2_q;
  assign fill_x     = cur_x_q;
  assign fill_y     = cur_y_q;
  assign pix_x      = cur_x_q;
  assign pix_y      = cur_y_q;

endmodule
